// File: rtl/axi_lite_array_arbiter_pkg.sv
// Shared constants for the AXI4-Lite array arbiter: response code, FSM encoding
// and read/write grant identifiers.
package axi_lite_pkg;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_RESP = 2'd2,
        ST_WR_RESP = 2'd3
    } state_t;

    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } grant_t;
endpackage

// File: rtl/axi_lite_array_arbiter_if.sv
// AXI4-Lite channel bundle between the requester and the array arbiter.
interface axi_lite_array_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_array_arbiter_hold_reg.sv
// One-entry valid/ready holding register; the consumer drains it with clear.
module axi_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         clear,
    output logic         full,
    output logic [W-1:0] data
);
    // Ready drops with reset so nothing is accepted while the block is held.
    assign in_ready = !full & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (in_valid && in_ready) begin
            full <= 1'b1;
            data <= in_data;
        end else if (clear) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/axi_lite_array_arbiter.sv
// AXI4-Lite slave front end sharing one single-port word array between buffered
// read and write requests under round-robin arbitration.
module axi_lite_array_arbiter
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    axi_lite_array_arbiter_if.slave s_axi,
    output logic [ADDR_W-3:0]     mem_addr,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);
    localparam int WA     = ADDR_W - 2;
    localparam int STRB_W = DATA_W / 8;

    logic                     ar_full, aw_full, w_full;
    logic [WA-1:0]            ar_waddr, aw_waddr, addr_q;
    logic [DATA_W+STRB_W-1:0] w_hold;
    logic                     rd_grant, wr_grant, wr_req;
    logic                     rvalid_q, bvalid_q;
    logic [DATA_W-1:0]        rdata_q;
    state_t                   state, state_nxt;
    grant_t                   last_grant;
    logic                     unused_addr_lsbs;

    // Byte-lane bits never reach the array.
    assign unused_addr_lsbs = ^{s_axi.araddr[1:0], s_axi.awaddr[1:0]};

    axi_hold_reg #(.W(WA)) u_ar (
        .clk(s_axi_aclk), .rst_n(s_axi_aresetn), .in_valid(s_axi.arvalid),
        .in_data(s_axi.araddr[ADDR_W-1:2]), .in_ready(s_axi.arready),
        .clear(rd_grant), .full(ar_full), .data(ar_waddr)
    );

    axi_hold_reg #(.W(WA)) u_aw (
        .clk(s_axi_aclk), .rst_n(s_axi_aresetn), .in_valid(s_axi.awvalid),
        .in_data(s_axi.awaddr[ADDR_W-1:2]), .in_ready(s_axi.awready),
        .clear(wr_grant), .full(aw_full), .data(aw_waddr)
    );

    axi_hold_reg #(.W(DATA_W+STRB_W)) u_w (
        .clk(s_axi_aclk), .rst_n(s_axi_aresetn), .in_valid(s_axi.wvalid),
        .in_data({s_axi.wstrb, s_axi.wdata}), .in_ready(s_axi.wready),
        .clear(wr_grant), .full(w_full), .data(w_hold)
    );

    assign wr_req = aw_full & w_full;

    always_comb begin
        state_nxt = state;
        rd_grant  = 1'b0;
        wr_grant  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Read wins a tie only when write was served last.
                if (ar_full && (!wr_req || last_grant == GNT_WRITE)) begin
                    rd_grant  = 1'b1;
                    state_nxt = ST_RD_WAIT;
                end else if (wr_req) begin
                    wr_grant  = 1'b1;
                    state_nxt = ST_WR_RESP;
                end
            end
            ST_RD_WAIT: state_nxt = ST_RD_RESP;
            ST_RD_RESP: if (s_axi.rready) state_nxt = ST_IDLE;
            ST_WR_RESP: if (s_axi.bready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state      <= ST_IDLE;
            last_grant <= GNT_WRITE;
            addr_q     <= '0;
            rvalid_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state <= state_nxt;
            if (rd_grant) begin
                last_grant <= GNT_READ;
                addr_q     <= ar_waddr;
            end
            if (wr_grant) begin
                last_grant <= GNT_WRITE;
                addr_q     <= aw_waddr;
                bvalid_q   <= 1'b1;
            end
            if (state == ST_RD_WAIT) begin
                rdata_q  <= mem_rdata;
                rvalid_q <= 1'b1;
            end
            if (state == ST_RD_RESP && s_axi.rready) rvalid_q <= 1'b0;
            if (state == ST_WR_RESP && s_axi.bready) bvalid_q <= 1'b0;
        end
    end

    // Address is driven combinationally in the grant cycle, then held for the
    // array's one-cycle read latency and beyond.
    assign mem_addr  = rd_grant ? ar_waddr : (wr_grant ? aw_waddr : addr_q);
    assign mem_we    = wr_grant;
    assign mem_be    = w_hold[DATA_W +: STRB_W];
    assign mem_wdata = w_hold[DATA_W-1:0];

    assign s_axi.rdata  = rdata_q;
    assign s_axi.rvalid = rvalid_q;
    assign s_axi.rresp  = RESP_OKAY;
    assign s_axi.bvalid = bvalid_q;
    assign s_axi.bresp  = RESP_OKAY;
endmodule

// File: doc/axi_lite_array_arbiter.md
Name: axi_lite_array_arbiter

Overview:
AXI4-Lite slave front end that shares one single-port word array between read and write requesters.
- Buffers the AR, AW and W channels in one-entry holding registers.
- Arbitrates read against write round-robin and drives the array's port.
- Returns R data and B responses with full valid/ready handshakes.
- Sits between the top-level s_axi_* pins and the array instance, replacing direct stream wiring.

Parameters:
ADDR_W, 9, AXI byte-address width; word address is addr[ADDR_W-1:2].
DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
s_axi_aclk  in  1  clock; all logic on the rising edge
s_axi_aresetn  in  1  asynchronous active-low reset
s_axi_awaddr  in  ADDR_W  write address
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_W  write data
s_axi_wstrb  in  DATA_W/8  byte strobes
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bresp  out  2  write response; always 2'b00 (OKAY)
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_araddr  in  ADDR_W  read address
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rdata  out  DATA_W  read data (registered)
s_axi_rresp  out  2  read response; always 2'b00 (OKAY)
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
mem_addr  out  ADDR_W-2  array word address
mem_we  out  1  one-cycle write enable
mem_be  out  DATA_W/8  byte enables (wstrb)
mem_wdata  out  DATA_W  array write data
mem_rdata  in  DATA_W  array read data; valid one cycle after address presented

Behaviour:
- Reset is asynchronous and active-low. While s_axi_aresetn=0:
  - all holding flags (ar_full, aw_full, w_full) clear;
  - state=IDLE; bvalid=0, rvalid=0, rdata=0, mem_we=0;
  - last_grant=WRITE, so the first tie goes to read.
  - Reset mid-transaction discards buffered requests; no write is committed.
- Ready signals:
  - awready = !aw_full & aresetn; wready = !w_full & aresetn; arready = !ar_full & aresetn.
  - Each handshake captures addr/data/strb and sets its flag at the edge.
  - AW and W are accepted independently, in either order or the same cycle.
- Requests:
  - rd_req = ar_full.
  - wr_req = aw_full & w_full.
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_RESP.
- IDLE:
  - Grant read if rd_req and (!wr_req or last_grant==WRITE).
  - Grant write if wr_req and (!rd_req or last_grant==READ).
  - The grant is combinational within the IDLE cycle. No grant: mem_we=0, mem_addr holds its last value.
- Read grant:
  - mem_addr=ar word address, mem_we=0.
  - Clear ar_full, set last_grant=READ, go to RD_WAIT.
- RD_WAIT:
  - Capture mem_rdata into rdata; set rvalid=1; go to RD_RESP.
- RD_RESP:
  - Hold rvalid and rdata stable until rready.
  - On the rready edge: rvalid=0, go to IDLE.
- Write grant:
  - mem_we=1 for exactly this cycle, with mem_addr=aw word address, mem_be=wstrb, mem_wdata=wdata.
  - Clear aw_full and w_full, set last_grant=WRITE, set bvalid=1, go to WR_RESP.
  - wstrb==0 still produces a B response with no bytes written.
- WR_RESP:
  - Hold bvalid until bready; then bvalid=0, go to IDLE.
- Latency:
  - Read: AR handshake at edge E0 gives rvalid high after E2, with zero back-pressure and IDLE at E0.
  - Write: bvalid goes high one edge after the edge at which the later of AW/W was captured.
- Buffering during responses:
  - New AR/AW/W may be captured while in RD_*/WR_RESP (flags empty).
  - The buffered request issues on the first IDLE cycle after the response completes.
  - rready/bready seen in IDLE is ignored.
- Address handling: addr[1:0] is ignored; no SLVERR generated.

Decomposition:
- Shared package axi_lite_pkg: RESP_OKAY=2'b00, FSM state encoding, READ/WRITE grant constants.
- One sub-module axi_hold_reg (parameterized width):
  - one-entry valid/ready holding register with a clear input;
  - instantiated three times (AR, AW, W+strb).

Test Plan:
- Write addr 0x010, data 0xDEADBEEF, wstrb 4'hF, bready=1 -> mem_we pulses once, mem_addr=4, mem_be=F; bvalid high one edge after capture, bresp=00.
- Read 0x010 after that write, array returns 0xDEADBEEF -> rvalid high two edges after AR handshake, rdata=0xDEADBEEF, rresp=00.
- W presented 3 cycles before AW -> no mem_we until AW captured; wready low while w_full.
- AR and AW+W captured the same edge from reset -> read granted first, write next; then alternate under continuous load (R,W,R,W).
- rready held low 5 cycles -> rvalid/rdata stable; a second AR is accepted and buffered; arready=0 for a third AR; its read issues after first R handshake.
- Assert reset with aw_full=1 and w_full=1 mid-WR_RESP -> bvalid=0 immediately, no further mem_we, all readies re-assert after release.
